// File: rtl/hevc_interp_pkg.sv
`default_nettype none
// ============================================================================
// hevc_interp_pkg : shared window-buffer state type and width helpers
// Revision: 1.0
// ============================================================================
package hevc_interp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } win_state_e;

  localparam int c_DEFAULT_PIX_W = 8;

  function automatic int win_bits(input int depth, input int row_pix, input int pix_w);
    return depth * row_pix * pix_w;
  endfunction

  function automatic int cnt_bits(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_transpose.sv
`default_nettype none
// ============================================================================
// window_transpose : row-major to column-major window reorder (PIXEL_WINDOW_TRANSPOSE_EN only)
// Revision: 1.0
// ============================================================================
`ifdef PIXEL_WINDOW_TRANSPOSE_EN
module window_transpose
  import hevc_interp_pkg::*;
#(
  parameter int ROW_PIX = 8,
  parameter int DEPTH   = 15,
  parameter int PIX_W   = c_DEFAULT_PIX_W
) (
  input  logic [DEPTH*ROW_PIX*PIX_W-1:0] row_major_i,
  output logic [DEPTH*ROW_PIX*PIX_W-1:0] col_major_o
);

  // Lane j gathers pixel j of every row, oldest row in the lowest position.
  for (genvar j = 0; j < ROW_PIX; j++) begin : g_lane
    for (genvar r = 0; r < DEPTH; r++) begin : g_row
      assign col_major_o[(j*DEPTH + r)*PIX_W +: PIX_W] =
             row_major_i[(r*ROW_PIX + j)*PIX_W +: PIX_W];
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/pixel_window_buffer.sv
`default_nettype none
// ============================================================================
// pixel_window_buffer : sliding DEPTH-row window with block framing; PIXEL_WINDOW_TRANSPOSE_EN selects column-major output
// Revision: 1.0
// ============================================================================
module pixel_window_buffer
  import hevc_interp_pkg::*;
#(
  parameter int PIX_W    = c_DEFAULT_PIX_W,
  parameter int ROW_PIX  = 8,
  parameter int DEPTH    = 15,
  parameter int BLK_ROWS = 15
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sof,
  input  logic [ROW_PIX*PIX_W-1:0]         in_row,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic                             win_last,
  output logic [DEPTH*ROW_PIX*PIX_W-1:0]   win_data,
  output logic [$clog2(DEPTH+1)-1:0]       fill,
  output logic                             err_drop
);

  localparam int c_ROW_W  = ROW_PIX * PIX_W;
  localparam int c_WIN_W  = win_bits(DEPTH, ROW_PIX, PIX_W);
  localparam int c_FILL_W = cnt_bits(DEPTH);
  localparam int c_CNT_W  = cnt_bits(BLK_ROWS);

  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(DEPTH);
  localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);
  localparam logic [c_CNT_W-1:0]  c_ROW_LAST  = c_CNT_W'(BLK_ROWS);
  localparam logic [c_CNT_W-1:0]  c_ROW_ONE   = c_CNT_W'(1);

  win_state_e                      state_q, state_d, w_state_eff;
  logic [DEPTH-1:0][c_ROW_W-1:0]   slot_q, slot_d;
  logic [c_FILL_W-1:0]             fill_q, fill_d, w_fill_inc;
  logic [c_CNT_W-1:0]              rowcnt_q, rowcnt_d, w_row_inc;
  logic                            win_valid_q, win_valid_d;
  logic                            win_last_q, win_last_d;
  logic                            err_drop_q, err_drop_d;
  logic                            w_acc, w_hs, w_blk_done;
  logic [c_WIN_W-1:0]              w_row_major;

  assign in_ready   = !reset && (!win_valid_q || win_ready);
  assign w_acc      = in_valid && in_ready;
  assign w_hs       = win_valid_q && win_ready;
  assign w_blk_done = w_hs && win_last_q;
  assign w_fill_inc = fill_q + 1'b1;
  assign w_row_inc  = rowcnt_q + 1'b1;
  // A row arriving with the final handshake is judged as if already in IDLE.
  assign w_state_eff = w_blk_done ? IDLE : state_q;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    fill_d      = fill_q;
    rowcnt_d    = rowcnt_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    err_drop_d  = err_drop_q;

    if (w_hs) begin
      win_valid_d = 1'b0;
    end
    if (w_blk_done) begin
      win_last_d = 1'b0;
      fill_d     = '0;
      rowcnt_d   = '0;
      state_d    = IDLE;
    end

    if (w_acc) begin
      if (in_sof) begin
        slot_d            = '0;
        slot_d[DEPTH-1]   = in_row;
        fill_d            = c_FILL_ONE;
        rowcnt_d          = c_ROW_ONE;
        win_valid_d       = 1'b0;
        win_last_d        = 1'b0;
        state_d           = FILL;
      end else begin
        unique case (w_state_eff)
          FILL: begin
            slot_d   = {in_row, slot_q[DEPTH-1:1]};
            fill_d   = w_fill_inc;
            rowcnt_d = w_row_inc;
            if (w_fill_inc == c_FILL_FULL) begin
              win_valid_d = 1'b1;
              state_d     = STREAM;
            end
            if (w_row_inc == c_ROW_LAST) begin
              win_last_d = 1'b1;
            end
          end
          STREAM: begin
            slot_d      = {in_row, slot_q[DEPTH-1:1]};
            rowcnt_d    = w_row_inc;
            win_valid_d = 1'b1;
            if (w_row_inc == c_ROW_LAST) begin
              win_last_d = 1'b1;
            end
          end
          default: begin
            err_drop_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      fill_q      <= '0;
      rowcnt_q    <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      fill_q      <= fill_d;
      rowcnt_q    <= rowcnt_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign w_row_major = slot_q;
  assign win_valid   = win_valid_q;
  assign win_last    = win_last_q;
  assign fill        = fill_q;
  assign err_drop    = err_drop_q;

`ifdef PIXEL_WINDOW_TRANSPOSE_EN
  window_transpose #(
    .ROW_PIX (ROW_PIX),
    .DEPTH   (DEPTH),
    .PIX_W   (PIX_W)
  ) u_transpose (
    .row_major_i (w_row_major),
    .col_major_o (win_data)
  );
`else
  assign win_data = w_row_major;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_window_buffer.sv
`default_nettype none
// ============================================================================
// tb_pixel_window_buffer : scoreboard bench with a row-history reference model
// Revision: 1.0
// ============================================================================
module tb_pixel_window_buffer;

  localparam int PIX_W    = 8;
  localparam int ROW_PIX  = 2;
  localparam int DEPTH    = 3;
  localparam int BLK_ROWS = 5;
  localparam int ROW_W    = ROW_PIX * PIX_W;
  localparam int WIN_W    = DEPTH * ROW_W;
  localparam int FILL_W   = $clog2(DEPTH + 1);

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_sof = 1'b0;
  logic               win_ready = 1'b0;
  logic [ROW_W-1:0]   in_row = '0;
  logic               in_ready, win_valid, win_last, err_drop;
  logic [WIN_W-1:0]   win_data;
  logic [FILL_W-1:0]  fill;

  pixel_window_buffer #(
    .PIX_W    (PIX_W),
    .ROW_PIX  (ROW_PIX),
    .DEPTH    (DEPTH),
    .BLK_ROWS (BLK_ROWS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_row    (in_row),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last),
    .win_data  (win_data),
    .fill      (fill),
    .err_drop  (err_drop)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIN_W-1:0] data;
    logic             last;
  } win_t;

  // Reference model: the rows of the current block (last DEPTH kept) and
  // the windows that are due to be presented.
  win_t              exp_q[$];
  logic [ROW_W-1:0]  hist[$];
  int                nrows = 0;
  bit                active = 1'b0;
  logic [FILL_W-1:0] exp_fill = '0;
  bit                exp_err = 1'b0;
  int                checks = 0;
  int                passed = 0;

  task automatic check_vec(input string nm, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
  endtask

  // Window seen by the filter: last DEPTH rows of the block, oldest first,
  // zero rows standing in for the slots cleared at start of block.
  function automatic logic [WIN_W-1:0] window_of();
    logic [WIN_W-1:0] w;
    logic [ROW_W-1:0] row;
    int               idx;
    w = '0;
    for (int r = 0; r < DEPTH; r++) begin
      idx = hist.size() - DEPTH + r;
      row = (idx >= 0) ? hist[idx] : '0;
`ifdef PIXEL_WINDOW_TRANSPOSE_EN
      for (int j = 0; j < ROW_PIX; j++)
        w[(j*DEPTH + r)*PIX_W +: PIX_W] = row[j*PIX_W +: PIX_W];
`else
      w[r*ROW_W +: ROW_W] = row;
`endif
    end
    return w;
  endfunction

  task automatic model_accept(input logic [ROW_W-1:0] row, input logic sof);
    win_t w;
    if (sof) begin
      exp_q.delete();
      hist.delete();
      hist.push_back(row);
      nrows    = 1;
      active   = 1'b1;
      exp_fill = FILL_W'(1);
    end else if (!active) begin
      exp_err = 1'b1;
    end else begin
      hist.push_back(row);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      nrows++;
      exp_fill = FILL_W'((nrows < DEPTH) ? nrows : DEPTH);
      if (nrows >= DEPTH) begin
        w.data = window_of();
        w.last = (nrows == BLK_ROWS);
        exp_q.push_back(w);
        if (nrows == BLK_ROWS) active = 1'b0;
      end
    end
  endtask

  // Output monitor: compares what the DUT presents, retires taken windows.
  always @(negedge clock) begin
    if (reset) begin
      check_bit("in_ready_in_reset", in_ready, 1'b0);
    end else begin
      check_bit("in_ready", in_ready, (exp_q.size() == 0) || win_ready);
      check_bit("win_valid", win_valid, exp_q.size() != 0);
      check_vec("fill", WIN_W'(fill), WIN_W'(exp_fill));
      check_bit("err_drop", err_drop, exp_err);
      check_vec("storage", win_data, window_of());
      if (exp_q.size() != 0) begin
        check_vec("win_data", win_data, exp_q[0].data);
        check_bit("win_last", win_last, exp_q[0].last);
        if (win_ready) begin
          if (exp_q[0].last) exp_fill = '0;
          void'(exp_q.pop_front());
        end
      end else begin
        check_bit("win_last_idle", win_last, 1'b0);
      end
    end
  end

  // Stimulus recorder: every row the DUT will take at the next edge goes
  // through the reference model.
  always @(negedge clock) begin
    #1;
    if (reset) begin
      exp_q.delete();
      hist.delete();
      nrows    = 0;
      active   = 1'b0;
      exp_fill = '0;
      exp_err  = 1'b0;
    end else if (in_valid && in_ready) begin
      model_accept(in_row, in_sof);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic probe();
    @(negedge clock);
    #3;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] row, input logic sof);
    int  n;
    bit  taken;
    n = 0;
    taken = 1'b0;
    in_valid = 1'b1;
    in_row   = row;
    in_sof   = sof;
    while (!taken && n < 64) begin
      @(negedge clock);
      #2;
      if (in_ready) taken = 1'b1;
      else n++;
      step();
    end
    if (!taken) begin
      checks++;
      $display("FAIL send_timeout: row %0h not accepted within 64 cycles", row);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    probe();
    check_bit("rst_win_valid", win_valid, 1'b0);
    check_bit("rst_win_last", win_last, 1'b0);
    check_vec("rst_fill", WIN_W'(fill), '0);
    check_bit("rst_err_drop", err_drop, 1'b0);
    check_vec("rst_win_data", win_data, '0);
    step();

`ifndef PIXEL_WINDOW_TRANSPOSE_EN
    // Fill, stream and block end
    win_ready = 1'b1;
    send_row(16'h0101, 1'b1);
    send_row(16'h0202, 1'b0);
    send_row(16'h0303, 1'b0);
    probe();
    check_bit("s1_valid", win_valid, 1'b1);
    check_vec("s1_data", win_data, 48'h030302020101);
    check_vec("s1_fill", WIN_W'(fill), WIN_W'(3));
    check_bit("s1_last", win_last, 1'b0);
    step();
    send_row(16'h0404, 1'b0);
    probe();
    check_vec("s2_data_a", win_data, 48'h040403030202);
    check_bit("s2_last_a", win_last, 1'b0);
    step();
    send_row(16'h0505, 1'b0);
    probe();
    check_vec("s2_data_b", win_data, 48'h050504040303);
    check_bit("s2_last_b", win_last, 1'b1);
    step();
    probe();
    check_vec("s2_fill_end", WIN_W'(fill), '0);
    check_bit("s2_valid_end", win_valid, 1'b0);
    step();

    // Backpressure with a row waiting
    send_row(16'h0101, 1'b1);
    probe();
    check_vec("s3_fill_sof", WIN_W'(fill), WIN_W'(1));
    step();
    send_row(16'h0202, 1'b0);
    win_ready = 1'b0;
    send_row(16'h0303, 1'b0);
    in_valid = 1'b1;
    in_row   = 16'h0909;
    in_sof   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      probe();
      check_bit("s3_stall_ready", in_ready, 1'b0);
      check_vec("s3_stall_data", win_data, 48'h030302020101);
      step();
    end
    win_ready = 1'b1;
    probe();
    check_bit("s3_release_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    probe();
    check_bit("s3_next_valid", win_valid, 1'b1);
    check_vec("s3_next_data", win_data, 48'h090903030202);
    step();

    // Block end, stray row, mid-block restart
    send_row(16'h0505, 1'b0);
    send_row(16'h0707, 1'b0);
    probe();
    check_bit("s4_err_drop", err_drop, 1'b1);
    check_vec("s4_fill_idle", WIN_W'(fill), '0);
    step();
    send_row(16'h0101, 1'b1);
    send_row(16'h0202, 1'b0);
    send_row(16'h0A0A, 1'b1);
    probe();
    check_vec("s4_fill_restart", WIN_W'(fill), WIN_W'(1));
    check_vec("s4_data_restart", win_data, 48'h0A0A00000000);
    check_bit("s4_valid_restart", win_valid, 1'b0);
    step();

    // Reset while a window is pending
    send_row(16'h0B0B, 1'b0);
    win_ready = 1'b0;
    send_row(16'h0C0C, 1'b0);
    probe();
    check_bit("s5_pending", win_valid, 1'b1);
    step();
    reset = 1'b1;
    probe();
    check_bit("s5_ready_in_reset", in_ready, 1'b0);
    step();
    reset = 1'b0;
    probe();
    check_bit("s5_valid", win_valid, 1'b0);
    check_bit("s5_last", win_last, 1'b0);
    check_vec("s5_fill", WIN_W'(fill), '0);
    check_bit("s5_err", err_drop, 1'b0);
    check_vec("s5_data", win_data, '0);
    check_bit("s5_ready_after", in_ready, 1'b1);
    step();
`else
    // Column-major output
    win_ready = 1'b1;
    send_row(16'h0201, 1'b1);
    send_row(16'h0403, 1'b0);
    send_row(16'h0605, 1'b0);
    probe();
    check_bit("s6_valid", win_valid, 1'b1);
    check_vec("s6_data", win_data, 48'h060402050301);
    step();
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sof    = ($urandom_range(0, 9) == 0);
      in_row    = ROW_W'($urandom);
      win_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
